if_id_buffer: RTL and testbench
===============================

// Module: if_id_buffer
// PURPOSE
//  Two-entry fetch/decode buffer directly downstream of the fetch stage (PC, add4, memory, jump mux).
//  Captures {PC, instruction} pairs from fetch under a valid/ready handshake.
//  Presents the oldest entry to decode, with pre-split MIPS fields and a precomputed J-type target.
//  Flushes on a jump redirect, and flags null (all-zero) instructions as a sticky error.
// PARAMETERS
//  DEPTH     2            entries; only 2 is supported (pointer logic is 1 bit)
//  OP_J      6'h02        opcode of J
//  OP_JAL    6'h03        opcode of JAL
// PORTS
//  clk            in   1   rising-edge clock
//  reset          in   1   asynchronous reset, active high
//  in_valid       in   1   fetch presents a pair this cycle
//  in_ready       out  1   buffer accepts the pair this cycle
//  in_pc          in   32  address of the fetched instruction
//  in_inst        in   32  fetched instruction word
//  flush          in   1   discard all entries (jump/branch redirect)
//  out_valid      out  1   head entry valid
//  out_ready      in   1   decode consumes the head this cycle
//  out_pc         out  32  head PC
//  out_pc4        out  32  head PC + 4
//  out_inst       out  32  head instruction
//  out_opcode     out  6   inst[31:26]
//  out_rs         out  5   inst[25:21]
//  out_rt         out  5   inst[20:16]
//  out_rd         out  5   inst[15:11]
//  out_shamt      out  5   inst[10:6]
//  out_funct      out  6   inst[5:0]
//  out_imm_sext   out  32  {{16{inst[15]}}, inst[15:0]}
//  out_jtarget    out  32  {pc4[31:28], inst[25:0], 2'b00}
//  out_is_jump    out  1   opcode == OP_J or OP_JAL
//  count          out  2   occupancy, 0..2
//  null_seen      out  1   sticky: an all-zero instruction was accepted
// BEHAVIOUR
//  Reset (async, immediate)
//   - count=0, read/write pointers=0, null_seen=0, out_valid=0.
//   - Entry storage is not cleared; data outputs are don't-care while out_valid=0.
//  Handshake
//   - in_ready  = (count != 2); combinational from state only.
//   - out_valid = (count != 0).
//   - push = in_valid & in_ready & ~flush.
//   - pop  = out_valid & out_ready & ~flush.
//   - Push writes entry[wptr] and toggles wptr. Pop toggles rptr.
//   - count' = count + push - pop. Push and pop in the same cycle with count=1 leave count=1.
//   - No bypass: a pushed pair is visible on out_* no earlier than the next cycle (latency 1).
//  Outputs
//   - All out_* fields are combinational decodes of entry[rptr].
//   - pc4 = out_pc + 32'd4, modulo 2^32: 32'hFFFFFFFC -> 0.
//  Flush
//   - On the clk edge with flush=1: count=0, rptr=wptr=0; any push/pop that cycle is ignored.
//   - null_seen is preserved across flush.
//  Null detection
//   - On push with in_inst==32'h0, null_seen goes to 1 and stays 1 until reset.
//   - The entry is still stored.
//  Overflow/underflow
//   - in_valid while full: no write; fetch must hold its data.
//   - out_ready while empty: no state change.
//  Reset asserted mid-transfer: entries are lost; in_ready=1 once reset is released.
// TESTING
//  T1 reset, then push pc=0x00400000 inst=0x08100001 -> next cycle: out_valid=1,
//     out_is_jump=1, out_jtarget=0x00400004, count=1.
//  T2 push 3 pairs back-to-back with out_ready=0 -> in_ready=0 after the 2nd push;
//     3rd held; count=2; head is the 1st pair.
//  T3 count=1, simultaneous push+pop -> count stays 1; head becomes the pushed pair; order preserved.
//  T4 count=2, flush=1 with in_valid=1 -> next cycle count=0, out_valid=0, in_ready=1; nothing stored.
//  T5 push inst=0x8C28FFFC (lw) -> rs=1, rt=8, imm_sext=0xFFFFFFFC, out_is_jump=0.
//     Push inst=0 -> null_seen=1, and it stays 1 after flush.
//  T6 pc=0xFFFFFFFC -> out_pc4=0x00000000.
//     Assert reset while count=2 -> out_valid=0 immediately, without waiting for clk.

Source files
------------

// File: rtl/if_id_buffer_if.sv
// Fetch/decode handshake bundle for the two-entry IF/ID buffer.
// slave: buffer side; master: fetch+decode (testbench) side.
interface if_id_buffer_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_inst;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_pc4;
  logic [31:0] out_inst;
  logic [5:0]  out_opcode;
  logic [4:0]  out_rs;
  logic [4:0]  out_rt;
  logic [4:0]  out_rd;
  logic [4:0]  out_shamt;
  logic [5:0]  out_funct;
  logic [31:0] out_imm_sext;
  logic [31:0] out_jtarget;
  logic        out_is_jump;
  logic [1:0]  count;
  logic        null_seen;

  modport slave (
    input  in_valid, in_pc, in_inst, flush, out_ready,
    output in_ready, out_valid, out_pc, out_pc4, out_inst,
    output out_opcode, out_rs, out_rt, out_rd, out_shamt,
    output out_funct, out_imm_sext, out_jtarget, out_is_jump,
    output count, null_seen
  );

  modport master (
    output in_valid, in_pc, in_inst, flush, out_ready,
    input  in_ready, out_valid, out_pc, out_pc4, out_inst,
    input  out_opcode, out_rs, out_rt, out_rd, out_shamt,
    input  out_funct, out_imm_sext, out_jtarget, out_is_jump,
    input  count, null_seen
  );
endinterface

// File: rtl/if_id_buffer.sv
// Two-entry IF/ID buffer: captures {pc, inst} from fetch, presents the
// oldest entry pre-decoded to ID. Ports: clk, reset (async high), bus.
module if_id_buffer #(
  parameter int        DEPTH  = 2,
  parameter logic [5:0] OP_J   = 6'h02,
  parameter logic [5:0] OP_JAL = 6'h03
) (
  input  logic       clk,
  input  logic       reset,
  if_id_buffer_if.slave bus
);

  logic [31:0] r_pc   [2];
  logic [31:0] r_inst [2];
  logic        r_wptr;
  logic        r_rptr;
  logic [1:0]  r_count;
  logic        r_null;

  logic        w_full;
  logic        w_push;
  logic        w_pop;
  logic [31:0] w_pc;
  logic [31:0] w_inst;
  logic [31:0] w_pc4;

  assign w_full = (r_count == 2'(DEPTH));
  assign w_push = bus.in_valid & ~w_full & ~bus.flush;
  assign w_pop  = (r_count != 2'd0) & bus.out_ready & ~bus.flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_count <= 2'd0;
      r_null  <= 1'b0;
    end else if (bus.flush) begin
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (w_push) r_wptr <= ~r_wptr;
      if (w_pop)  r_rptr <= ~r_rptr;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
      if (w_push && bus.in_inst == 32'h0) r_null <= 1'b1;
    end
  end

  // Payload is not reset; outputs are don't-care while empty.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc[r_wptr]   <= bus.in_pc;
      r_inst[r_wptr] <= bus.in_inst;
    end
  end

  assign w_pc   = r_pc[r_rptr];
  assign w_inst = r_inst[r_rptr];
  assign w_pc4  = w_pc + 32'd4;

  assign bus.in_ready     = ~w_full;
  assign bus.out_valid    = (r_count != 2'd0);
  assign bus.count        = r_count;
  assign bus.null_seen    = r_null;
  assign bus.out_pc       = w_pc;
  assign bus.out_pc4      = w_pc4;
  assign bus.out_inst     = w_inst;
  assign bus.out_opcode   = w_inst[31:26];
  assign bus.out_rs       = w_inst[25:21];
  assign bus.out_rt       = w_inst[20:16];
  assign bus.out_rd       = w_inst[15:11];
  assign bus.out_shamt    = w_inst[10:6];
  assign bus.out_funct    = w_inst[5:0];
  assign bus.out_imm_sext = {{16{w_inst[15]}}, w_inst[15:0]};
  assign bus.out_jtarget  = {w_pc4[31:28], w_inst[25:0], 2'b00};
  assign bus.out_is_jump  = (w_inst[31:26] == OP_J) ||
                            (w_inst[31:26] == OP_JAL);

endmodule

// File: tb/tb_if_id_buffer.sv
// Testbench for if_id_buffer: directed scenarios then random traffic,
// checked against a queue-based reference model.
module tb_if_id_buffer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  if_id_buffer_if bus ();

  if_id_buffer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int vectors = 0;
  int miss    = 0;

  logic [31:0] q_pc   [$];
  logic [31:0] q_inst [$];
  logic        m_null = 1'b0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [31:0] pc, in, pc4, imm;
    int n;
    n = q_pc.size();
    chk("count", 32'(bus.count), 32'(n));
    chk("out_valid", 32'(bus.out_valid), 32'(n != 0));
    chk("in_ready", 32'(bus.in_ready), 32'(n < 2));
    chk("null_seen", 32'(bus.null_seen), 32'(m_null));
    if (n != 0) begin
      pc  = q_pc[0];
      in  = q_inst[0];
      pc4 = pc + 32'd4;
      imm = in & 32'h0000FFFF;
      if (in >= 32'h0 && ((in >> 15) & 32'h1) == 32'h1)
        imm = imm | 32'hFFFF0000;
      chk("pc", bus.out_pc, pc);
      chk("pc4", bus.out_pc4, pc4);
      chk("inst", bus.out_inst, in);
      chk("opcode", 32'(bus.out_opcode), (in >> 26) & 32'h3F);
      chk("rs", 32'(bus.out_rs), (in >> 21) & 32'h1F);
      chk("rt", 32'(bus.out_rt), (in >> 16) & 32'h1F);
      chk("rd", 32'(bus.out_rd), (in >> 11) & 32'h1F);
      chk("shamt", 32'(bus.out_shamt), (in >> 6) & 32'h1F);
      chk("funct", 32'(bus.out_funct), in & 32'h3F);
      chk("imm", bus.out_imm_sext, imm);
      chk("jtarget", bus.out_jtarget,
          (pc4 & 32'hF0000000) | ((in & 32'h03FFFFFF) << 2));
      chk("is_jump", 32'(bus.out_is_jump),
          32'(((in >> 26) == 32'd2) || ((in >> 26) == 32'd3)));
    end
  endtask

  // One clock: drive at negedge, check state-derived outputs, then
  // advance the model across the rising edge.
  task automatic step(logic v, logic [31:0] pc, logic [31:0] in,
                      logic fl, logic rdy);
    bit push, pop;
    @(negedge clk);
    bus.in_valid  = v;
    bus.in_pc     = pc;
    bus.in_inst   = in;
    bus.flush     = fl;
    bus.out_ready = rdy;
    #1;
    check_all();
    push = v && q_pc.size() < 2 && !fl;
    pop  = rdy && q_pc.size() > 0 && !fl;
    @(posedge clk);
    if (fl) begin
      q_pc.delete();
      q_inst.delete();
    end else begin
      if (pop) begin
        void'(q_pc.pop_front());
        void'(q_inst.pop_front());
      end
      if (push) begin
        q_pc.push_back(pc);
        q_inst.push_back(in);
        if (in == 32'h0) m_null = 1'b1;
      end
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_pc     = '0;
    bus.in_inst   = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    #12;
    reset = 1'b0;

    // T1: J-type push, visible next cycle
    step(1, 32'h00400000, 32'h08100001, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("t1_jt", bus.out_jtarget, 32'h00400004);
    chk("t1_jump", 32'(bus.out_is_jump), 32'd1);

    // T2: three back-to-back pushes while decode stalls
    step(0, 0, 0, 1, 0);
    step(1, 32'h00000100, 32'h00221820, 0, 0);
    step(1, 32'h00000104, 32'h00431022, 0, 0);
    step(1, 32'h00000108, 32'h11111111, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("t2_full", 32'(bus.in_ready), 32'd0);
    chk("t2_head", bus.out_pc, 32'h00000100);

    // T3: count=1, push+pop together
    step(0, 0, 0, 0, 1);
    step(1, 32'h0000010C, 32'h0C000040, 0, 1);
    step(0, 0, 0, 0, 0);
    chk("t3_cnt", 32'(bus.count), 32'd1);
    chk("t3_head", bus.out_pc, 32'h0000010C);

    // T4: flush while full with in_valid high
    step(1, 32'h00000200, 32'h22222222, 0, 0);
    step(1, 32'h00000204, 32'h33333333, 1, 1);
    step(0, 0, 0, 0, 0);
    chk("t4_cnt", 32'(bus.count), 32'd0);

    // T5: lw decode, then null instruction is sticky across flush
    step(1, 32'h00400010, 32'h8C28FFFC, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("t5_imm", bus.out_imm_sext, 32'hFFFFFFFC);
    chk("t5_rt", 32'(bus.out_rt), 32'd8);
    step(1, 32'h00400014, 32'h00000000, 0, 1);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0);
    chk("t5_null", 32'(bus.null_seen), 32'd1);

    // T6: pc4 wrap, then async reset while full
    step(1, 32'hFFFFFFFC, 32'h08000000, 0, 0);
    step(1, 32'h00000010, 32'h00000020, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("t6_pc4", bus.out_pc4, 32'h00000000);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_rst_v", 32'(bus.out_valid), 32'd0);
    chk("t6_rst_n", 32'(bus.null_seen), 32'd0);
    q_pc.delete();
    q_inst.delete();
    m_null = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    step(0, 0, 0, 0, 0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      logic [31:0] in;
      in = ($urandom_range(0, 15) == 0) ? 32'h0 : $urandom();
      if ($urandom_range(0, 7) == 0) in = {6'($urandom_range(2, 3)), 26'($urandom())};
      step(1'($urandom_range(0, 1)), $urandom(), in,
           $urandom_range(0, 19) == 0, 1'($urandom_range(0, 1)));
    end
    step(0, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
    $finish;
  end

endmodule
